prbs_word_gen: RTL and testbench
================================

Name: prbs_word_gen

Overview:
- Parallel test-pattern source that directly feeds the differential output stage (diff_out) on the GBS20 SERDES bench.
- Produces one WORDWIDTH-bit word per enabled clock.
- Patterns: PRBS7, a fixed word, an incrementing counter, or an alternating clock pattern.
- Supports seed load, single-shot error injection, and produced/injected word counters for link BER tests.

Parameters:
- WORDWIDTH, 16, output word width; must be ≥ 8.
- CNTWIDTH, 32, width of the word and error counters.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  when high, produce one word this cycle.
- mode  input  2  pattern select: 0 PRBS7, 1 fixed, 2 counter, 3 alternating.
- fixed_pattern  input  WORDWIDTH  word sent in mode 1.
- seed  input  7  PRBS7 seed value.
- seed_load  input  1  pulse: load seed into the LFSR.
- err_inj  input  1  pulse: request an inverted LSB on the next produced word.
- word_out  output  WORDWIDTH  registered pattern word, connected to diff_out sig_in.
- word_valid  output  1  high for one cycle per produced word.
- word_cnt  output  CNTWIDTH  number of words produced; wraps.
- err_cnt  output  CNTWIDTH  number of errors injected; wraps.

Behaviour:
- Reset values (async, immediate on rst high): word_out=0, word_valid=0, lfsr=7'h7F, pattern counter=0, alt phase=0, inj_pending=0, word_cnt=0, err_cnt=0.
- Latency: enable sampled high at edge N gives word_out/word_valid updated at edge N. The word is visible one cycle after enable is asserted. No combinational input-to-output paths.
- enable low: word_out holds its value, word_valid=0, no state advances.
- PRBS7 polynomial x^7+x^6+1, serial step:
  - b = s[6]^s[5]; s <= {s[5:0], b}.
  - One word = WORDWIDTH sequential steps computed in one cycle.
  - The first generated bit goes to word_out[WORDWIDTH-1] (MSB first).
  - The LFSR holds the post-word state.
  - The LFSR advances only on words produced in mode 0.
- Mode 1: word_out = fixed_pattern, sampled in the producing cycle.
- Mode 2: word_out = pattern counter value, then the counter increments. WORDWIDTH-bit, wraps all-ones→0. It advances only in mode 2.
- Mode 3: word_out alternates {..1010} (LSB 0) and its inverse. It starts with {..1010} after reset and toggles phase per produced word in mode 3 only.
- Mode change: takes effect on the next produced word. The other generators keep their state (no restart).
- seed_load:
  - Loads lfsr=seed; seed 7'h00 is forced to 7'h7F (lock-up protection).
  - In that cycle no word is produced (word_valid=0, word_out held) even if enable is high.
  - Counters are unaffected.
- err_inj:
  - Sets inj_pending. The next produced word (any mode) has bit 0 inverted, err_cnt increments, and inj_pending clears.
  - If err_inj and a produced word coincide, that word is the one corrupted.
  - Further err_inj pulses while already pending are merged (one injection).
  - Injection never alters LFSR/counter state.
- word_cnt increments on every produced word.
- Reset mid-stream: all outputs return to reset values immediately. After release, the PRBS sequence restarts from 7'h7F.

Test Plan:
- Reset, mode=0, enable high for 2 cycles → word_valid=1 each cycle; first word_out=16'h020C, LFSR=7'h0C after it; word_cnt=1 then 2.
- mode=0, enable continuously for 127 words → sequence repeats exactly at word 128 (PRBS7 period 127 bits, gcd with 16 = 1 ⇒ word period 127); no all-zero LFSR state.
- seed_load with seed=7'h00 and enable=1 same cycle → no word_valid that cycle, LFSR=7'h7F; next word=16'h020C.
- mode=1, fixed_pattern=16'hA5A5, err_inj pulse while enable=0, then enable → first word 16'hA5A4, err_cnt=1; second word 16'hA5A5.
- mode=2 from reset, 3 words → 0000,0001,0002. Switch to mode 3 for 2 words → AAAA,5555. Back to mode 2 → 0003. enable toggling low holds word_out, word_valid=0.
- Assert rst mid-stream in mode 0 → outputs 0 immediately. After release, the first word=16'h020C and word_cnt restarts from 1.

Source files
------------

// File: rtl/prbs_word_gen_if.sv
// rtl/prbs_word_gen_if.sv - control and word-stream bundle of the PRBS word generator
interface prbs_word_gen_if #(
   parameter int WORDWIDTH = 16,
   parameter int CNTWIDTH  = 32
);
   logic                 enable;
   logic [1:0]           mode;
   logic [WORDWIDTH-1:0] fixed_pattern;
   logic [6:0]           seed;
   logic                 seed_load;
   logic                 err_inj;
   logic [WORDWIDTH-1:0] word_out;
   logic                 word_valid;
   logic [CNTWIDTH-1:0]  word_cnt;
   logic [CNTWIDTH-1:0]  err_cnt;

   modport master (
      output enable, mode, fixed_pattern, seed, seed_load, err_inj,
      input  word_out, word_valid, word_cnt, err_cnt
   );

   modport slave (
      input  enable, mode, fixed_pattern, seed, seed_load, err_inj,
      output word_out, word_valid, word_cnt, err_cnt
   );
endinterface

// File: rtl/prbs_word_gen.sv
// rtl/prbs_word_gen.sv - parallel PRBS7/fixed/counter/alternating word source with error injection
module prbs_word_gen #(
   parameter int WORDWIDTH = 16,
   parameter int CNTWIDTH  = 32
) (
   input  logic            clk,
   input  logic            rst,
   prbs_word_gen_if.slave  bus
);
   localparam logic [6:0]           LFSR_INIT = 7'h7F;
   localparam logic [WORDWIDTH-1:0] PAT_ONE   = WORDWIDTH'(1);
   localparam logic [CNTWIDTH-1:0]  CNT_ONE   = CNTWIDTH'(1);

   typedef enum logic [1:0] {
      MODE_PRBS  = 2'd0,
      MODE_FIXED = 2'd1,
      MODE_COUNT = 2'd2,
      MODE_ALT   = 2'd3
   } mode_e;

   logic [WORDWIDTH-1:0] word_q, word_d;
   logic                 valid_q, valid_d;
   logic [6:0]           lfsr_q, lfsr_d;
   logic [WORDWIDTH-1:0] pat_q, pat_d;
   logic                 alt_q, alt_d;
   logic                 pend_q, pend_d;
   logic [CNTWIDTH-1:0]  wcnt_q, wcnt_d;
   logic [CNTWIDTH-1:0]  ecnt_q, ecnt_d;

   logic [6:0]           prbs_state;
   logic [WORDWIDTH-1:0] prbs_word;
   logic                 prbs_fb;
   logic [WORDWIDTH-1:0] alt_base;
   logic [WORDWIDTH-1:0] pattern_word;
   logic                 produce;
   logic                 inject;
   mode_e                mode_sel;

   // WORDWIDTH serial LFSR steps unrolled; first feedback bit lands in the MSB
   always_comb begin
      prbs_state = lfsr_q;
      prbs_word  = '0;
      prbs_fb    = 1'b0;
      for (int i = WORDWIDTH - 1; i >= 0; i--) begin
         prbs_fb      = prbs_state[6] ^ prbs_state[5];
         prbs_word[i] = prbs_fb;
         prbs_state   = {prbs_state[5:0], prbs_fb};
      end
   end

   always_comb begin
      alt_base = '0;
      for (int i = 0; i < WORDWIDTH; i++) begin
         alt_base[i] = (i % 2) == 1;
      end
   end

   assign mode_sel = mode_e'(bus.mode);
   assign produce  = bus.enable & ~bus.seed_load;
   assign inject   = produce & (pend_q | bus.err_inj);

   always_comb begin
      pattern_word = prbs_word;
      case (mode_sel)
         MODE_PRBS:  pattern_word = prbs_word;
         MODE_FIXED: pattern_word = bus.fixed_pattern;
         MODE_COUNT: pattern_word = pat_q;
         MODE_ALT:   pattern_word = alt_q ? ~alt_base : alt_base;
         default:    pattern_word = prbs_word;
      endcase
   end

   always_comb begin
      word_d  = word_q;
      valid_d = 1'b0;
      lfsr_d  = lfsr_q;
      pat_d   = pat_q;
      alt_d   = alt_q;
      pend_d  = pend_q;
      wcnt_d  = wcnt_q;
      ecnt_d  = ecnt_q;

      // all-zero seed would lock the LFSR, so it falls back to the reset state
      if (bus.seed_load) begin
         lfsr_d = (bus.seed == 7'h00) ? LFSR_INIT : bus.seed;
      end

      if (produce) begin
         valid_d = 1'b1;
         word_d  = inject ? (pattern_word ^ PAT_ONE) : pattern_word;
         wcnt_d  = wcnt_q + CNT_ONE;
         case (mode_sel)
            MODE_PRBS:  lfsr_d = prbs_state;
            MODE_COUNT: pat_d  = pat_q + PAT_ONE;
            MODE_ALT:   alt_d  = ~alt_q;
            default:    ;
         endcase
      end

      if (inject) begin
         pend_d = 1'b0;
         ecnt_d = ecnt_q + CNT_ONE;
      end else if (bus.err_inj) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q  <= '0;
         valid_q <= 1'b0;
         lfsr_q  <= LFSR_INIT;
         pat_q   <= '0;
         alt_q   <= 1'b0;
         pend_q  <= 1'b0;
         wcnt_q  <= '0;
         ecnt_q  <= '0;
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
         lfsr_q  <= lfsr_d;
         pat_q   <= pat_d;
         alt_q   <= alt_d;
         pend_q  <= pend_d;
         wcnt_q  <= wcnt_d;
         ecnt_q  <= ecnt_d;
      end
   end

   assign bus.word_out   = word_q;
   assign bus.word_valid = valid_q;
   assign bus.word_cnt   = wcnt_q;
   assign bus.err_cnt    = ecnt_q;
endmodule

// File: tb/tb_prbs_word_gen.sv
// tb/tb_prbs_word_gen.sv - self-checking bench for prbs_word_gen
module tb_prbs_word_gen;
   localparam int W = 16;
   localparam int C = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   prbs_word_gen_if #(.WORDWIDTH(W), .CNTWIDTH(C)) bus ();
   prbs_word_gen #(.WORDWIDTH(W), .CNTWIDTH(C)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic         en;
      logic [1:0]   mode;
      logic [15:0]  fixed;
      logic [6:0]   seed;
      logic         sl;
      logic         ei;
      logic         ev;
      logic [15:0]  ew;
      logic [31:0]  ewc;
      logic [31:0]  eec;
   } vec_t;

   vec_t vecs[20];

   // reference model: PRBS7 as the bit recurrence b[n] = b[n-7] ^ b[n-6]
   bit          m_hist[$];
   int unsigned m_cnt, m_wcnt, m_ecnt;
   bit          m_phase, m_pend, m_valid;
   logic [15:0] m_word;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_hist.delete();
      for (int i = 0; i < 7; i++) m_hist.push_back(1'b1);
      m_cnt = 0; m_wcnt = 0; m_ecnt = 0;
      m_phase = 0; m_pend = 0; m_valid = 0; m_word = '0;
   endtask

   task automatic model_step(input bit en, input bit [1:0] mode, input bit [15:0] fixed,
                             input bit [6:0] seed, input bit sl, input bit ei);
      logic [15:0] w;
      bit b;
      m_valid = 0;
      if (sl) begin
         m_hist.delete();
         for (int i = 6; i >= 0; i--) m_hist.push_back(seed == 0 ? 1'b1 : seed[i]);
      end
      if (en && !sl) begin
         w = '0;
         case (mode)
            2'd0: for (int k = 0; k < 16; k++) begin
                     b = m_hist[0] ^ m_hist[1];
                     void'(m_hist.pop_front());
                     m_hist.push_back(b);
                     w = {w[14:0], b};
                  end
            2'd1: w = fixed;
            2'd2: begin w = 16'(m_cnt); m_cnt = (m_cnt + 1) % 65536; end
            default: begin w = m_phase ? 16'h5555 : 16'hAAAA; m_phase = !m_phase; end
         endcase
         if (m_pend || ei) begin
            w[0] = !w[0];
            m_ecnt++;
            m_pend = 0;
         end
         m_word = w;
         m_valid = 1;
         m_wcnt++;
      end else if (ei) begin
         m_pend = 1;
      end
   endtask

   task automatic drive(input bit en, input bit [1:0] mode, input bit [15:0] fixed,
                        input bit [6:0] seed, input bit sl, input bit ei);
      bus.enable = en; bus.mode = mode; bus.fixed_pattern = fixed;
      bus.seed = seed; bus.seed_load = sl; bus.err_inj = ei;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      bus.enable = 0; bus.seed_load = 0; bus.err_inj = 0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   logic [15:0] first_words[127];
   logic [15:0] w128;
   bit          saw_zero;
   int          prev_wcnt;

   initial begin
      bus.enable = 0; bus.mode = 0; bus.fixed_pattern = 0;
      bus.seed = 0; bus.seed_load = 0; bus.err_inj = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_word", bus.word_out, 16'h0);
      check("reset_valid", bus.word_valid, 1'b0);
      check("reset_wcnt", bus.word_cnt, 32'd0);
      check("reset_ecnt", bus.err_cnt, 32'd0);
      rst = 1'b0;

      //              en mode fixed      seed   sl ei  ev ew        wcnt ecnt
      vecs[0]  = '{1, 2'd0, 16'h0,    7'h00, 0, 0, 1, 16'h020C, 1,  0};
      vecs[1]  = '{1, 2'd0, 16'h0,    7'h00, 0, 0, 1, 16'h28F2, 2,  0};
      vecs[2]  = '{1, 2'd2, 16'h0,    7'h00, 0, 0, 1, 16'h0000, 3,  0};
      vecs[3]  = '{1, 2'd2, 16'h0,    7'h00, 0, 0, 1, 16'h0001, 4,  0};
      vecs[4]  = '{1, 2'd2, 16'h0,    7'h00, 0, 0, 1, 16'h0002, 5,  0};
      vecs[5]  = '{1, 2'd3, 16'h0,    7'h00, 0, 0, 1, 16'hAAAA, 6,  0};
      vecs[6]  = '{1, 2'd3, 16'h0,    7'h00, 0, 0, 1, 16'h5555, 7,  0};
      vecs[7]  = '{1, 2'd2, 16'h0,    7'h00, 0, 0, 1, 16'h0003, 8,  0};
      vecs[8]  = '{0, 2'd2, 16'h0,    7'h00, 0, 0, 0, 16'h0003, 8,  0};
      vecs[9]  = '{0, 2'd1, 16'hA5A5, 7'h00, 0, 1, 0, 16'h0003, 8,  0};
      vecs[10] = '{1, 2'd1, 16'hA5A5, 7'h00, 0, 0, 1, 16'hA5A4, 9,  1};
      vecs[11] = '{1, 2'd1, 16'hA5A5, 7'h00, 0, 0, 1, 16'hA5A5, 10, 1};
      vecs[12] = '{1, 2'd0, 16'hA5A5, 7'h00, 1, 0, 0, 16'hA5A5, 10, 1};
      vecs[13] = '{1, 2'd0, 16'h0,    7'h00, 0, 0, 1, 16'h020C, 11, 1};
      vecs[14] = '{0, 2'd0, 16'h0,    7'h7F, 1, 0, 0, 16'h020C, 11, 1};
      vecs[15] = '{0, 2'd0, 16'h0,    7'h00, 0, 1, 0, 16'h020C, 11, 1};
      vecs[16] = '{0, 2'd0, 16'h0,    7'h00, 0, 1, 0, 16'h020C, 11, 1};
      vecs[17] = '{1, 2'd2, 16'h0,    7'h00, 0, 0, 1, 16'h0005, 12, 2};
      vecs[18] = '{1, 2'd2, 16'h0,    7'h00, 0, 0, 1, 16'h0005, 13, 2};
      vecs[19] = '{1, 2'd1, 16'h1234, 7'h00, 0, 1, 1, 16'h1235, 14, 3};

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].en, vecs[i].mode, vecs[i].fixed, vecs[i].seed, vecs[i].sl, vecs[i].ei);
         check($sformatf("vec%0d_valid", i), bus.word_valid, vecs[i].ev);
         check($sformatf("vec%0d_word", i), bus.word_out, vecs[i].ew);
         check($sformatf("vec%0d_wcnt", i), bus.word_cnt, vecs[i].ewc);
         check($sformatf("vec%0d_ecnt", i), bus.err_cnt, vecs[i].eec);
      end
      drive(1, 2'd0, 16'h0, 7'h0C, 1, 0);
      drive(1, 2'd0, 16'h0, 7'h00, 0, 0);
      check("seed0C_word", bus.word_out, 16'h28F2);

      // PRBS7 word period is 127 words
      do_reset();
      saw_zero = 0;
      for (int i = 0; i < 127; i++) begin
         drive(1, 2'd0, 16'h0, 7'h00, 0, 0);
         first_words[i] = bus.word_out;
         if (bus.word_out == 16'h0) saw_zero = 1;
      end
      check("period_first", first_words[0], 16'h020C);
      check("period_no_zero", saw_zero, 1'b0);
      check("period_not_short", first_words[63] == first_words[0], 1'b0);
      drive(1, 2'd0, 16'h0, 7'h00, 0, 0);
      w128 = bus.word_out;
      check("period_repeat", w128, first_words[0]);
      drive(1, 2'd0, 16'h0, 7'h00, 0, 0);
      check("period_repeat2", bus.word_out, first_words[1]);
      check("period_wcnt", bus.word_cnt, 32'd129);

      // asynchronous reset mid-stream
      bus.err_inj = 1;
      #2 rst = 1'b1;
      #1;
      check("midrst_word", bus.word_out, 16'h0);
      check("midrst_valid", bus.word_valid, 1'b0);
      check("midrst_wcnt", bus.word_cnt, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1, 2'd0, 16'h0, 7'h00, 0, 0);
      check("postrst_word", bus.word_out, 16'h020C);
      check("postrst_wcnt", bus.word_cnt, 32'd1);
      check("postrst_ecnt", bus.err_cnt, 32'd0);

      // randomized run against the model
      do_reset();
      model_reset();
      for (int i = 0; i < 600; i++) begin
         bit en, sl, ei;
         bit [1:0] md;
         bit [15:0] fx;
         bit [6:0] sd;
         en = $urandom_range(0, 3) != 0;
         sl = $urandom_range(0, 15) == 0;
         ei = $urandom_range(0, 9) == 0;
         md = 2'($urandom_range(0, 3));
         fx = 16'($urandom);
         sd = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
         drive(en, md, fx, sd, sl, ei);
         model_step(en, md, fx, sd, sl, ei);
         check("rand_valid", bus.word_valid, m_valid);
         check("rand_word", bus.word_out, m_word);
         check("rand_wcnt", bus.word_cnt, 32'(m_wcnt));
         check("rand_ecnt", bus.err_cnt, 32'(m_ecnt));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
